// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle MIPS-subset core with shared ALU and control FSM
// Optional jump instruction enabled by defining MULTICYCLE_JUMP_EN.
module multicycle_datapath #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              illegal
);

  localparam int RIDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int DIDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur_state, next_state;

  logic [DATA_W-1:0] pc, alu_out, a, b, mdr;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [5:0]        op, funct;
  logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [DIDX_W-1:0] dmem_idx;
  logic [DATA_W-1:0] sext, alu_res, wb_val;
  logic              is_r, r_ok, is_addi, is_lw, is_sw, is_beq, is_j, legal;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs_idx   = ir[21+RIDX_W-1:21];
  assign rt_idx   = ir[16+RIDX_W-1:16];
  assign rd_idx   = ir[11+RIDX_W-1:11];
  assign sext     = DATA_W'($signed(ir[15:0]));
  assign dmem_idx = alu_out[DIDX_W+1:2];

  assign is_r    = (op == 6'h00);
  assign r_ok    = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                   (funct == 6'h25) || (funct == 6'h2A);
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
`ifdef MULTICYCLE_JUMP_EN
  logic [63:0] jump_wide;
  assign is_j      = (op == 6'h02);
  assign jump_wide = {64'(pc) >> 28, ir[25:0], 2'b00};
`else
  assign is_j = 1'b0;
`endif
  assign legal = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

  always_comb begin
    alu_res = a + sext;
    if (is_r) begin
      case (funct)
        6'h20:   alu_res = a + b;
        6'h22:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2A:   alu_res = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
        default: alu_res = '0;
      endcase
    end
  end

  assign wb_idx = is_r ? rd_idx : rt_idx;
  assign wb_val = is_lw ? mdr : alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    instr_done = 1'b0;
    case (cur_state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (!legal || is_j) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (is_sw) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = WB;
        end
      end
      WB: begin
        instr_done = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      result  <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (cur_state)
        FETCH: begin
          ir <= imem_data;
          pc <= pc + DATA_W'(4);
        end
        DECODE: begin
          a       <= regs[rs_idx];
          b       <= regs[rt_idx];
          alu_out <= pc + (sext << 2);
          if (!legal) illegal <= 1'b1;
`ifdef MULTICYCLE_JUMP_EN
          if (is_j) pc <= jump_wide[DATA_W-1:0];
`endif
        end
        EXEC: begin
          if (is_beq) begin
            if (a == b) pc <= alu_out;
          end else begin
            alu_out <= alu_res;
          end
        end
        MEM: begin
          if (is_lw) mdr <= dmem[dmem_idx];
        end
        WB: begin
          // Register 0 is never written, so it reads back as zero.
          if (wb_idx != '0) regs[wb_idx] <= wb_val;
          result <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // Data memory is not reset; the store is gated so a reset edge cannot commit it.
  always_ff @(posedge clk) begin
    if (!rst && cur_state == MEM && is_sw) dmem[dmem_idx] <= b;
  end

  assign imem_addr = pc;
  assign state     = cur_state;

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle MIPS-subset processor core: the successor to the single-cycle datapath.
- One shared ALU and a control FSM sequence each instruction over 3-5 cycles.
- Instruction memory is external (combinational read). The data memory and register bank are internal.
- Exposes the last written-back value as `result`, plus FSM/status observation ports for the bench.

Parameters:
- DATA_W, 32, datapath/PC/register width; legal range 16..64.
- REG_COUNT, 32, register bank entries; power of 2, 2..32; register index = field modulo REG_COUNT.
- DMEM_DEPTH, 64, data memory words; power of 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  DATA_W  byte address of instruction (= PC)
- imem_data  in  32  instruction at imem_addr, combinational
- result  out  DATA_W  last value written into the register bank
- state  out  3  current FSM state encoding
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky flag: unsupported opcode/funct decoded

Behaviour:
- Reset (async, rst=1):
  - PC=0; IR, A, B, ALUOut and MDR = 0.
  - All registers = 0; result=0; illegal=0; instr_done=0; state=FETCH.
  - Data memory contents are not reset.
  - Reset asserted mid-instruction aborts it; no partial register or memory write may occur in that cycle.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH: IR<=imem_data; PC<=PC+4 (wraps modulo 2^DATA_W) -> DECODE.
- DECODE:
  - A<=R[rs], B<=R[rt].
  - ALUOut<=PC+(sext(imm)<<2), the branch target.
  - Unsupported opcode: set illegal, pulse instr_done -> FETCH (executes as a NOP).
  - R-type with unsupported funct: handled the same way.
- EXEC:
  - R-type: ALUOut<=A op B -> WB.
  - addi: ALUOut<=A+sext(imm) -> WB.
  - lw/sw: ALUOut<=A+sext(imm) -> MEM.
  - beq: if A==B then PC<=ALUOut; pulse instr_done -> FETCH.
- MEM:
  - lw: MDR<=dmem[ALUOut[log2(DMEM_DEPTH)+1:2]] -> WB.
  - sw: dmem[same index]<=B; pulse instr_done -> FETCH.
  - Address bits [1:0] are ignored. Upper bits wrap modulo DMEM_DEPTH.
- WB:
  - Destination: R-type writes rd with ALUOut; addi writes rt with ALUOut; lw writes rt with MDR.
  - result<=written value even when the destination is register 0.
  - Pulse instr_done -> FETCH.
- Register 0 always reads 0; writes to it are discarded.
- Supported encodings:
  - opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed; result 1/0).
  - opcode 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq.
- Arithmetic:
  - Wrap-around modulo 2^DATA_W; no overflow trap.
  - sext extends imm[15] up to DATA_W.
- Cycle counts: R-type 4, addi 4, lw 5, sw 4, beq 3, illegal 2.
- Register file reads in DECODE see every write completed in an earlier WB (no forwarding needed).

Optional Feature:
- Macro: MULTICYCLE_JUMP_EN.
- Defined:
  - opcode 0x02 (j) is legal.
  - In DECODE: PC<={PC[DATA_W-1:28], target26, 2'b00}; pulse instr_done -> FETCH (2 cycles).
  - For DATA_W<32, the concatenation is truncated to DATA_W.
- Undefined: opcode 0x02 is illegal; it sets illegal and behaves as a NOP.

Test Plan:
- Reset mid-EXEC of an add (rst pulsed for 1 cycle) -> PC=0, state=0, result=0, no register changed, illegal=0.
- Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> result sequence 5, 0xFFFFFFFD, 2, 1; instr_done every 4 cycles; PC=16 at end.
- sw $1,8($0) then lw $5,8($0) with $1=0x1234 -> lw takes 5 cycles; result=0x1234. Then lw with offset 8+4*DMEM_DEPTH -> same 0x1234 (wrap).
- beq $1,$1,-1 at PC=0x20 -> branch taken in 3 cycles; imem_addr returns to 0x20. beq with unequal registers -> imem_addr=0x24.
- addi $0,$0,7 -> result=7, R[0] still reads 0. Opcode 0x3F -> illegal=1 and stays set; PC advances by 4 in 2 cycles.
- j 0x10 at PC=0 -> with MULTICYCLE_JUMP_EN, imem_addr=0x40 after 2 cycles; without it, illegal=1 and imem_addr=4.
